// File: rtl/counter_sequencer_if.sv
// Command and update-buffer handshake bundle for counter_sequencer.
// The master side is the command source and update consumer; the slave side is the sequencer.
interface counter_sequencer_if;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [2:0] i_cmd_op;
    logic [7:0] i_cmd_data;
    logic       o_upd_valid;
    logic       i_upd_ready;
    logic [7:0] o_upd_value;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_data, i_upd_ready,
        input  o_cmd_ready, o_upd_valid, o_upd_value
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_data, i_upd_ready,
        output o_cmd_ready, o_upd_valid, o_upd_value
    );
endinterface

// File: rtl/counter_sequencer.sv
// 8-bit run/stop counter advanced by a clock-enable prescaler tick and controlled by a command port.
// Each value change is published through a one-deep update buffer; COUNTER_SEQ_AUTOSTART_EN makes reset enter RUN.
module counter_sequencer #(
    parameter int INPUT_CLOCK_HZ = 27000000,
    parameter int INC_TIME_MS    = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    counter_sequencer_if.slave     bus,
    output logic [7:0]             o_value,
    output logic                   o_running,
    output logic                   o_dir_down,
    output logic                   o_wrap,
    output logic                   o_overrun
);
    localparam int TICK_CYC = INPUT_CLOCK_HZ / 1000 * INC_TIME_MS;
    localparam int PW       = $clog2(TICK_CYC);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);

    localparam logic [2:0] OP_START   = 3'd1;
    localparam logic [2:0] OP_STOP    = 3'd2;
    localparam logic [2:0] OP_CLEAR   = 3'd3;
    localparam logic [2:0] OP_LOAD    = 3'd4;
    localparam logic [2:0] OP_STEP    = 3'd5;
    localparam logic [2:0] OP_SET_DIR = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

`ifdef COUNTER_SEQ_AUTOSTART_EN
    localparam state_t RESET_STATE = S_RUN;
    localparam logic   RESET_RUN   = 1'b1;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   RESET_RUN   = 1'b0;
`endif

    state_t        r_state;
    logic          r_running;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_value;
    logic          r_dir_down;
    logic          r_wrap;
    logic          r_upd_valid;
    logic [7:0]    r_upd_value;
    logic          r_overrun;

    logic       w_accept;
    logic       w_tick;
    logic       w_cmd_value;
    logic       w_cmd_stop;
    logic       w_do_step;
    logic [7:0] w_next_value;
    logic       w_change;
    logic       w_wrap;

    assign bus.o_cmd_ready = !r_upd_valid || bus.i_upd_ready;
    assign bus.o_upd_valid = r_upd_valid;
    assign bus.o_upd_value = r_upd_value;
    assign o_value    = r_value;
    assign o_running  = r_running;
    assign o_dir_down = r_dir_down;
    assign o_wrap     = r_wrap;
    assign o_overrun  = r_overrun;

    assign w_accept    = bus.i_cmd_valid && bus.o_cmd_ready;
    assign w_tick      = (r_state == S_RUN) && (r_presc == TICK_LAST);
    assign w_cmd_value = w_accept && (bus.i_cmd_op == OP_CLEAR || bus.i_cmd_op == OP_LOAD ||
                                      bus.i_cmd_op == OP_STEP);
    assign w_cmd_stop  = w_accept && (bus.i_cmd_op == OP_STOP);
    // A tick colliding with a value-changing command or STOP is dropped, never merged.
    assign w_do_step   = (w_tick && !w_cmd_value && !w_cmd_stop) ||
                         (w_accept && bus.i_cmd_op == OP_STEP);

    always_comb begin
        w_next_value = r_value;
        w_change     = 1'b0;
        w_wrap       = 1'b0;
        if (w_accept && bus.i_cmd_op == OP_CLEAR) begin
            w_next_value = 8'd0;
            w_change     = 1'b1;
        end else if (w_accept && bus.i_cmd_op == OP_LOAD) begin
            w_next_value = bus.i_cmd_data;
            w_change     = 1'b1;
        end else if (w_do_step) begin
            w_next_value = r_dir_down ? r_value - 8'd1 : r_value + 8'd1;
            w_wrap       = r_dir_down ? (r_value == 8'h00) : (r_value == 8'hFF);
            w_change     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= RESET_STATE;
            r_running   <= RESET_RUN;
            r_presc     <= '0;
            r_value     <= 8'd0;
            r_dir_down  <= 1'b0;
            r_wrap      <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_value <= 8'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_value <= w_next_value;
            r_wrap  <= w_wrap;
            if (w_accept && bus.i_cmd_op == OP_SET_DIR)
                r_dir_down <= bus.i_cmd_data[0];

            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    if (w_accept && bus.i_cmd_op == OP_START) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_cmd_stop) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_presc   <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_presc   <= '0;
                end
            endcase

            // Commands can only land when the slot is free or being read, so overrun is tick-only.
            if (w_change) begin
                r_upd_value <= w_next_value;
                r_upd_valid <= 1'b1;
                r_overrun   <= r_upd_valid && !bus.i_upd_ready;
            end else begin
                r_overrun <= 1'b0;
                if (bus.i_upd_ready)
                    r_upd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer with a 10-cycle tick; expected update values are queued with the stimulus.
`timescale 1ns/1ps
module tb_counter_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] o_value;
    logic       o_running, o_dir_down, o_wrap, o_overrun;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];

    counter_sequencer_if bus();

    counter_sequencer #(.INPUT_CLOCK_HZ(10000), .INC_TIME_MS(1)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_value(o_value), .o_running(o_running), .o_dir_down(o_dir_down),
        .o_wrap(o_wrap), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Consumer side: every accepted update is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && bus.o_upd_valid && bus.i_upd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL update_unexpected: got %0h, no update expected", bus.o_upd_value);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.o_upd_value !== e)
                    $display("FAIL update_value: got %0h want %0h", bus.o_upd_value, e);
                else begin
                    n_pass++;
                    $display("update %0h consumed", bus.o_upd_value);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] data);
        int k;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = op;
        bus.i_cmd_data  = data;
        k = 0;
        while (!bus.o_cmd_ready && k < 20) begin
            cyc(1);
            k++;
        end
        if (k == 20) begin
            n_checks++;
            $display("FAIL cmd_timeout: op %0d not accepted within 20 cycles, want accept", op);
        end
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = 3'd0;
        $display("cmd op=%0d data=%0h sent, value=%0h", op, data, o_value);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        n_checks++; if (o_value !== 8'd0) $display("FAIL rst_value: got %0h want 0", o_value); else n_pass++;
        n_checks++; if (bus.o_upd_valid !== 1'b0) $display("FAIL rst_upd_valid: got %0b want 0", bus.o_upd_valid); else n_pass++;
        n_checks++; if (o_dir_down !== 1'b0 || o_wrap !== 1'b0 || o_overrun !== 1'b0)
            $display("FAIL rst_flags: got dir=%0b wrap=%0b ovr=%0b want 000", o_dir_down, o_wrap, o_overrun); else n_pass++;
        n_checks++; if (bus.o_cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %0b want 1", bus.o_cmd_ready); else n_pass++;
        rst = 1'b0;
`ifdef COUNTER_SEQ_AUTOSTART_EN
        exp_q.push_back(8'd1);
        cyc(9);
        n_checks++; if (o_value !== 8'd0) $display("FAIL auto_pre_tick: got %0h want 0", o_value); else n_pass++;
        cyc(1);
        n_checks++; if (o_value !== 8'd1) $display("FAIL auto_first_tick: got %0h want 1", o_value); else n_pass++;
        send_cmd(3'd2, 8'd0);
        exp_q.push_back(8'd0);
        send_cmd(3'd3, 8'd0);
        cyc(1);
`else
        cyc(20);
        n_checks++; if (o_value !== 8'd0 || o_running !== 1'b0)
            $display("FAIL idle_after_reset: got value=%0h run=%0b want 0/0", o_value, o_running); else n_pass++;
`endif
    endtask

    task automatic test_start_count();
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd2);
        send_cmd(3'd1, 8'd0);
        n_checks++; if (o_running !== 1'b1) $display("FAIL start_running: got %0b want 1", o_running); else n_pass++;
        cyc(9);
        n_checks++; if (o_value !== 8'd0) $display("FAIL start_cycle9: got %0h want 0", o_value); else n_pass++;
        cyc(1);
        n_checks++; if (o_value !== 8'd1 || bus.o_upd_valid !== 1'b1 || bus.o_upd_value !== 8'd1)
            $display("FAIL start_cycle10: got value=%0h uv=%0b uval=%0h want 1/1/1",
                     o_value, bus.o_upd_valid, bus.o_upd_value); else n_pass++;
        cyc(10);
        n_checks++; if (o_value !== 8'd2) $display("FAIL start_cycle20: got %0h want 2", o_value); else n_pass++;
        send_cmd(3'd2, 8'd0);
        exp_q.push_back(8'd0);
        send_cmd(3'd3, 8'd0);
        n_checks++; if (o_value !== 8'd0 || o_running !== 1'b0)
            $display("FAIL stop_clear: got value=%0h run=%0b want 0/0", o_value, o_running); else n_pass++;
    endtask

    task automatic test_wrap();
        int wraps;
        logic [7:0] wrap_val;
        wraps = 0;
        wrap_val = 8'h55;
        exp_q.push_back(8'hFE);
        send_cmd(3'd4, 8'hFE);
        n_checks++; if (o_wrap !== 1'b0) $display("FAIL load_no_wrap: got %0b want 0", o_wrap); else n_pass++;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_cmd(3'd1, 8'd0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (o_wrap) begin
                wraps++;
                wrap_val = o_value;
            end
        end
        n_checks++; if (wraps != 1 || wrap_val !== 8'h00)
            $display("FAIL wrap_up: got %0d pulses at value %0h want 1 at 0", wraps, wrap_val); else n_pass++;
        send_cmd(3'd2, 8'd0);
        send_cmd(3'd6, 8'd1);
        n_checks++; if (o_dir_down !== 1'b1 || o_value !== 8'h00)
            $display("FAIL set_dir: got dir=%0b value=%0h want 1/0", o_dir_down, o_value); else n_pass++;
        exp_q.push_back(8'hFF);
        send_cmd(3'd5, 8'd0);
        n_checks++; if (o_value !== 8'hFF || o_wrap !== 1'b1)
            $display("FAIL wrap_down: got value=%0h wrap=%0b want ff/1", o_value, o_wrap); else n_pass++;
        send_cmd(3'd6, 8'd0);
    endtask

    task automatic test_overrun();
        int ov_cnt, ov_first, ov_second;
        ov_cnt = 0; ov_first = -1; ov_second = -1;
        exp_q.push_back(8'd0);
        send_cmd(3'd3, 8'd0);
        cyc(1);
        bus.i_upd_ready = 1'b0;
        send_cmd(3'd1, 8'd0);
        for (int i = 1; i <= 30; i++) begin
            cyc(1);
            if (o_overrun) begin
                ov_cnt++;
                if (ov_cnt == 1) ov_first = i; else ov_second = i;
            end
            if (i == 15) begin
                n_checks++; if (bus.o_cmd_ready !== 1'b0)
                    $display("FAIL backpressure: got cmd_ready=%0b want 0", bus.o_cmd_ready); else n_pass++;
            end
        end
        n_checks++; if (ov_cnt != 2 || ov_first != 20 || ov_second != 30)
            $display("FAIL overrun_pulses: got %0d at %0d,%0d want 2 at 20,30", ov_cnt, ov_first, ov_second); else n_pass++;
        n_checks++; if (bus.o_upd_value !== 8'd3 || bus.o_upd_valid !== 1'b1)
            $display("FAIL overrun_slot: got uval=%0h uv=%0b want 3/1", bus.o_upd_value, bus.o_upd_valid); else n_pass++;
        exp_q.push_back(8'd3);
        bus.i_upd_ready = 1'b1;
        cyc(1);
        n_checks++; if (bus.o_upd_valid !== 1'b0) $display("FAIL read_clears: got %0b want 0", bus.o_upd_valid); else n_pass++;
        send_cmd(3'd2, 8'd0);
    endtask

    task automatic test_clear_on_tick();
        int bad;
        bad = 0;
        exp_q.push_back(8'd5);
        send_cmd(3'd4, 8'd5);
        send_cmd(3'd1, 8'd0);
        cyc(9);
        n_checks++; if (o_value !== 8'd5) $display("FAIL pre_clear: got %0h want 5", o_value); else n_pass++;
        exp_q.push_back(8'd0);
        send_cmd(3'd3, 8'd0);
        n_checks++; if (o_value !== 8'd0 || o_wrap !== 1'b0)
            $display("FAIL clear_on_tick: got value=%0h wrap=%0b want 0/0", o_value, o_wrap); else n_pass++;
        exp_q.push_back(8'd1);
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            if (o_value !== 8'd0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL clear_hold: got %0d bad cycles want 0", bad); else n_pass++;
        cyc(1);
        n_checks++; if (o_value !== 8'd1) $display("FAIL tick_after_clear: got %0h want 1", o_value); else n_pass++;
        send_cmd(3'd2, 8'd0);
    endtask

    task automatic test_stop_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (o_value !== 8'd1 || bus.o_upd_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL idle_hold: got %0d bad cycles want 0", bad); else n_pass++;
        exp_q.push_back(8'd2);
        send_cmd(3'd5, 8'd0);
        n_checks++; if (o_value !== 8'd2 || bus.o_upd_valid !== 1'b1 || bus.o_upd_value !== 8'd2)
            $display("FAIL idle_step: got value=%0h uv=%0b uval=%0h want 2/1/2",
                     o_value, bus.o_upd_valid, bus.o_upd_value); else n_pass++;
        cyc(1);
    endtask

    task automatic test_async_reset();
        send_cmd(3'd6, 8'd1);
        bus.i_upd_ready = 1'b0;
        send_cmd(3'd1, 8'd0);
        cyc(12);
        n_checks++; if (bus.o_upd_valid !== 1'b1 || o_value !== 8'd1)
            $display("FAIL pre_reset: got uv=%0b value=%0h want 1/1", bus.o_upd_valid, o_value); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (o_value !== 8'd0 || bus.o_upd_valid !== 1'b0 || bus.o_upd_value !== 8'd0 ||
                        o_dir_down !== 1'b0 || o_wrap !== 1'b0 || o_overrun !== 1'b0)
            $display("FAIL async_reset: got value=%0h uv=%0b uval=%0h dir=%0b want all 0",
                     o_value, bus.o_upd_valid, bus.o_upd_value, o_dir_down); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_upd_ready = 1'b1;
`ifdef COUNTER_SEQ_AUTOSTART_EN
        exp_q.push_back(8'd1);
        cyc(9);
        n_checks++; if (o_value !== 8'd0) $display("FAIL rel_pre_tick: got %0h want 0", o_value); else n_pass++;
        cyc(1);
        n_checks++; if (o_value !== 8'd1) $display("FAIL rel_first_tick: got %0h want 1", o_value); else n_pass++;
`else
        cyc(30);
        n_checks++; if (o_value !== 8'd0 || o_running !== 1'b0)
            $display("FAIL rel_idle: got value=%0h run=%0b want 0/0", o_value, o_running); else n_pass++;
`endif
        cyc(2);
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = 3'd0;
        bus.i_cmd_data  = 8'd0;
        bus.i_upd_ready = 1'b1;
        test_reset();
        test_start_count();
        test_wrap();
        test_overrun();
        test_clear_on_tick();
        test_stop_idle();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
